// File: rtl/uart_rx.sv
// 16x-oversampling UART receiver: synchronised serial line in, one-cycle
// valid / framing-error pulses out, with start-bit glitch rejection.
module uart_rx #(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce16_i,
  input  logic              ser_in_i,
  output logic [DATA_W-1:0] rx_data_o,
  output logic              rx_valid_o,
  output logic              frame_err_o,
  output logic              rx_busy_o
);

  localparam int BW = $clog2(DATA_W + 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } state_t;

  state_t                 state, state_next;
  logic [SYNC_STAGES-1:0] sync;
  logic                   line;
  logic [3:0]             tick, tick_next;
  logic [BW-1:0]          bits, bits_next;
  logic [DATA_W-1:0]      shift, shift_next;
  logic [DATA_W-1:0]      data_next;
  logic                   valid_next, ferr_next;

  assign line = sync[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync <= '1;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], ser_in_i};
    end
  end

  always_comb begin
    state_next = state;
    tick_next  = tick;
    bits_next  = bits;
    shift_next = shift;
    data_next  = rx_data_o;
    valid_next = 1'b0;
    ferr_next  = 1'b0;
    if (ce16_i) begin
      case (state)
        IDLE: begin
          if (!line) begin
            state_next = START;
            tick_next  = '0;
          end
        end
        START: begin
          // Re-check the line at mid start bit to reject short glitches
          if (tick == 4'd7) begin
            if (!line) begin
              state_next = DATA;
              tick_next  = '0;
              bits_next  = '0;
            end else begin
              state_next = IDLE;
            end
          end else begin
            tick_next = tick + 4'd1;
          end
        end
        DATA: begin
          if (tick == 4'd15) begin
            shift_next = {line, shift[DATA_W-1:1]};
            tick_next  = '0;
            bits_next  = bits + 1'b1;
            if (bits == BW'(DATA_W - 1)) begin
              state_next = STOP;
            end
          end else begin
            tick_next = tick + 4'd1;
          end
        end
        STOP: begin
          if (tick == 4'd15) begin
            tick_next = '0;
            if (line) begin
              data_next  = shift;
              valid_next = 1'b1;
              state_next = IDLE;
            end else begin
              ferr_next  = 1'b1;
              state_next = WAIT_IDLE;
            end
          end else begin
            tick_next = tick + 4'd1;
          end
        end
        WAIT_IDLE: begin
          if (line) begin
            state_next = IDLE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      tick        <= '0;
      bits        <= '0;
      shift       <= '0;
      rx_data_o   <= '0;
      rx_valid_o  <= 1'b0;
      frame_err_o <= 1'b0;
      rx_busy_o   <= 1'b0;
    end else begin
      state       <= state_next;
      tick        <= tick_next;
      bits        <= bits_next;
      shift       <= shift_next;
      rx_data_o   <= data_next;
      rx_valid_o  <= valid_next;
      frame_err_o <= ferr_next;
      rx_busy_o   <= (state_next != IDLE);
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: frames are pushed to a scoreboard as they are
// sent and popped when the receiver pulses valid.
`timescale 1ns/1ps
module tb_uart_rx;

  logic       clk;
  logic       rst;
  logic       ce16_i;
  logic       ser_in_i;
  logic [7:0] rx_data_o;
  logic       rx_valid_o;
  logic       frame_err_o;
  logic       rx_busy_o;

  int tests = 0;
  int fails = 0;
  int valid_cnt = 0;
  int ferr_cnt = 0;
  int ce_div = 1;
  int drive_off = 3;
  logic [7:0] q[$];

  uart_rx #(.DATA_W(8), .SYNC_STAGES(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .ce16_i     (ce16_i),
    .ser_in_i   (ser_in_i),
    .rx_data_o  (rx_data_o),
    .rx_valid_o (rx_valid_o),
    .frame_err_o(frame_err_o),
    .rx_busy_o  (rx_busy_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    int cnt;
    cnt = 0;
    ce16_i = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      cnt = (cnt + 1 >= ce_div) ? 0 : cnt + 1;
      ce16_i = (cnt == 0);
    end
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard consumer
  initial begin
    logic [7:0] exp;
    forever begin
      @(negedge clk);
      if (rx_valid_o || frame_err_o)
        check("valid_ferr_exclusive", {31'b0, rx_valid_o & frame_err_o}, 0);
      if (frame_err_o) ferr_cnt++;
      if (rx_valid_o) begin
        valid_cnt++;
        check("valid_expected", {31'b0, q.size() > 0}, 1);
        if (q.size() > 0) begin
          exp = q.pop_front();
          check("rx_data", {24'b0, rx_data_o}, {24'b0, exp});
        end
      end
    end
  end

  task automatic hold(input logic v, input int ticks);
    ser_in_i = v;
    repeat (ticks * ce_div) @(posedge clk);
    #(drive_off);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    hold(1'b0, 16);
    for (int i = 0; i < 8; i++) hold(d[i], 16);
    hold(stop, 16);
  endtask

  task automatic send_byte(input logic [7:0] d);
    q.push_back(d);
    send_frame(d, 1'b1);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 200 * ce_div) begin
      @(posedge clk);
      n++;
    end
    check("drain", q.size(), 0);
  endtask

  initial begin
    int v0, f0, gap;
    logic [7:0] d;
    rst = 1'b0;
    ser_in_i = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    check("rst_data", {24'b0, rx_data_o}, 0);
    check("rst_valid", {31'b0, rx_valid_o}, 0);
    check("rst_ferr", {31'b0, frame_err_o}, 0);
    check("rst_busy", {31'b0, rx_busy_o}, 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (5) @(posedge clk);
    #(drive_off);

    // 1: ce16 every clk, 0x55
    ce_div = 1;
    v0 = valid_cnt; f0 = ferr_cnt;
    send_byte(8'h55);
    wait_drain();
    check("t1_valid_count", valid_cnt - v0, 1);
    check("t1_ferr_count", ferr_cnt - f0, 0);
    check("t1_data_hold", {24'b0, rx_data_o}, 32'h55);

    // 2: ce16 every 4th clk, back-to-back frames
    ce_div = 4;
    hold(1'b1, 4);
    v0 = valid_cnt; f0 = ferr_cnt;
    send_byte(8'hA3);
    send_byte(8'h0F);
    wait_drain();
    check("t2_valid_count", valid_cnt - v0, 2);
    check("t2_ferr_count", ferr_cnt - f0, 0);
    check("t2_data_hold", {24'b0, rx_data_o}, 32'h0F);

    // 3: short start glitch
    ce_div = 1;
    hold(1'b1, 4);
    v0 = valid_cnt; f0 = ferr_cnt;
    hold(1'b0, 4);
    check("t3_busy_rise", {31'b0, rx_busy_o}, 1);
    hold(1'b1, 20);
    check("t3_busy_fall", {31'b0, rx_busy_o}, 0);
    check("t3_valid_count", valid_cnt - v0, 0);
    check("t3_ferr_count", ferr_cnt - f0, 0);

    // 4: framing error followed by a break
    v0 = valid_cnt; f0 = ferr_cnt;
    send_frame(8'h81, 1'b0);
    hold(1'b0, 40);
    check("t4_busy_break", {31'b0, rx_busy_o}, 1);
    check("t4_ferr_count", ferr_cnt - f0, 1);
    check("t4_valid_count", valid_cnt - v0, 0);
    check("t4_data_kept", {24'b0, rx_data_o}, 32'h0F);
    hold(1'b1, 20);
    check("t4_busy_release", {31'b0, rx_busy_o}, 0);
    check("t4_ferr_once", ferr_cnt - f0, 1);
    check("t4_no_restart", valid_cnt - v0, 0);

    // 5: reset during data bit 3
    d = 8'h5A;
    v0 = valid_cnt; f0 = ferr_cnt;
    hold(1'b0, 16);
    for (int i = 0; i < 3; i++) hold(d[i], 16);
    ser_in_i = d[3];
    repeat (5) @(posedge clk);
    #4;
    rst = 1'b0;
    #1;
    check("t5_rst_data", {24'b0, rx_data_o}, 0);
    check("t5_rst_valid", {31'b0, rx_valid_o}, 0);
    check("t5_rst_ferr", {31'b0, frame_err_o}, 0);
    check("t5_rst_busy", {31'b0, rx_busy_o}, 0);
    ser_in_i = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    hold(1'b1, 5);
    check("t5_no_pulse", (valid_cnt - v0) + (ferr_cnt - f0), 0);
    send_byte(8'hC6);
    wait_drain();
    check("t5_valid_count", valid_cnt - v0, 1);
    check("t5_data_hold", {24'b0, rx_data_o}, 32'hC6);

    // 6: random bytes with off-edge line changes
    v0 = valid_cnt; f0 = ferr_cnt;
    for (int n = 0; n < 256; n++) begin
      drive_off = $urandom_range(1, 9);
      gap = $urandom_range(0, 3);
      hold(1'b1, gap);
      d = 8'($urandom);
      send_byte(d);
    end
    wait_drain();
    check("t6_valid_count", valid_cnt - v0, 256);
    check("t6_ferr_count", ferr_cnt - f0, 0);
    check("final_queue_empty", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
